uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Buffers bytes from an upstream producer (e.g. Sobel result packer) in a small FIFO and paces them into uart_tx.
//  uart_tx has no busy/ready output, so this block issues one pi_flag pulse per byte, spaced by a fixed frame time.
//  It holds the byte stable on po_data for the whole frame. po_data/po_flag connect to uart_tx pi_data/pi_flag.
//  Both blocks run on the same clock with the same UART_BPS/CLK_FREQ.
// PARAMETERS
//  UART_BPS    'd9600        serial bit rate; must match uart_tx
//  CLK_FREQ    'd50_000_000  sys_clk frequency in Hz; must match uart_tx
//  FIFO_DEPTH  16            byte entries; power of two, 2..256
//  Derived: BAUD_CNT_MAX = CLK_FREQ/UART_BPS; FRAME_CYCLES = 11*BAUD_CNT_MAX (default 57288); FRAME_CYCLES < 2^20
// PORTS
//  sys_clk    in   1  single clock, all logic on rising edge
//  sys_rst_n  in   1  reset, synchronous, active-low
//  in_data    in   8  byte from producer
//  in_valid   in   1  in_data valid; producer holds data/valid until accepted
//  in_ready   out  1  FIFO can accept; transfer when in_valid && in_ready at a rising edge
//  clr        in   1  synchronous FIFO flush (1-cycle pulse or level)
//  po_data    out  8  byte to uart_tx pi_data; registered, held until next load
//  po_flag    out  1  1-cycle start pulse to uart_tx pi_flag; registered
//  busy       out  1  1 while a frame is in progress (states LOAD/SEND/WAIT)
//  fifo_cnt   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (sys_rst_n=0 at edge): po_data=8'h00, po_flag=0, busy=0, fifo_cnt=0, in_ready=1.
//  Reset also clears the pointers, sets state=IDLE and wait counter=0. FIFO memory contents are don't-care.
//  FIFO: in_ready = (fifo_cnt != FIFO_DEPTH), combinational from the count register.
//   Push and pop in the same cycle leave fifo_cnt unchanged. Pointers wrap modulo FIFO_DEPTH.
//   Full: in_ready=0 even if a pop occurs that cycle, so no push. Pop happens only in LOAD, and LOAD is entered only when fifo_cnt>0.
//  FSM states and transitions:
//   IDLE: if fifo_cnt>0, go to LOAD.
//   LOAD: pop the head into po_data, assert po_flag (registered), go to SEND.
//   SEND: po_flag is high during this cycle; it returns to 0 next edge. Go to WAIT and clear the counter.
//   WAIT: increment the counter. At FRAME_CYCLES-4 go to IDLE.
//  Timing requirements:
//   Consecutive po_flag pulses are exactly FRAME_CYCLES cycles apart while the FIFO stays non-empty.
//   Latency: a byte accepted at edge E0 into an empty idle block gives po_flag high in the cycle after edge E2.
//   po_data is valid from that same cycle.
//   po_data changes only in LOAD, so it is stable for the full uart_tx frame.
//  clr: on the next edge, zeroes fifo_cnt and both pointers; a push in the same cycle is discarded.
//   clr does not touch the FSM, po_data or po_flag, so an in-flight frame completes normally.
//   The block returns to IDLE with an empty FIFO.
//  Reset mid-frame: the FSM returns to IDLE at once and po_flag goes to 0.
//   The downstream uart_tx shares the reset, so no partial-frame handling is needed.
//  Wait counter: 20 bits, unsigned, cleared on entry to WAIT; it never wraps in legal configurations.
// TESTING (bench: CLK_FREQ=50_000_000, UART_BPS=1_000_000 -> FRAME_CYCLES=550; uart_tx instantiated downstream)
//  1 Reset, idle -> in_ready=1, fifo_cnt=0, po_flag never asserts, tx stays 1.
//  2 Push 8'hA5 once -> po_flag single pulse 2 cycles after the accept edge, po_data=8'hA5.
//    A serial monitor on tx decodes 0xA5 (start=0, LSB first, stop=1).
//  3 Push 0x01,0x02,0x03 back-to-back -> three po_flag pulses exactly 550 cycles apart.
//    tx decodes 01,02,03 in order; busy stays high throughout, then 0.
//  4 Push 17 bytes with valid held (DEPTH=16) -> in_ready low at fifo_cnt=16.
//    No byte is lost or duplicated; all 17 are decoded in order.
//  5 Push 4 bytes, assert clr during the first frame -> the first byte is transmitted completely.
//    Remaining bytes are dropped, fifo_cnt=0 next cycle, no further po_flag.
//  6 Assert sys_rst_n=0 mid-WAIT, then push 8'h3C -> all outputs at reset values.
//    0x3C is then sent with normal latency.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//
// Purpose:
//   Buffers bytes from an upstream producer in a small FIFO and paces them into
//   a uart_tx that has no busy/ready handshake. One po_flag pulse is issued per
//   byte, and consecutive pulses are spaced by a fixed frame time. The byte is
//   held stable on po_data for the whole serial frame.
//
// Ports:
//   sys_clk    in   1     single clock, rising edge
//   sys_rst_n  in   1     synchronous active-low reset
//   in_data    in   8     byte from producer
//   in_valid   in   1     in_data valid, held by producer until accepted
//   in_ready   out  1     FIFO not full; transfer on in_valid && in_ready
//   clr        in   1     synchronous FIFO flush (does not touch the FSM)
//   po_data    out  8     byte to uart_tx pi_data, changes only on load
//   po_flag    out  1     one-cycle start pulse to uart_tx pi_flag
//   busy       out  1     frame in progress (LOAD/SEND/WAIT)
//   fifo_cnt   out  AW+1  current FIFO occupancy
//
// FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no frame in progress; waits for a byte in the FIFO
//   LOAD    | pops the FIFO head into po_data and raises po_flag
//   SEND    | po_flag high this cycle; clears the frame counter
//   WAIT    | counts out the remainder of the serial frame
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int unsigned UART_BPS   = 'd9600,
  parameter int unsigned CLK_FREQ   = 'd50_000_000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          clr,
  output logic [7:0]                    po_data,
  output logic                          po_flag,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned CW           = AW + 1;
  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned FRAME_CYCLES = 11 * BAUD_CNT_MAX;

  // One frame = LOAD + SEND + WAIT(FRAME_CYCLES-3) + IDLE, so the last WAIT
  // cycle is the one where the counter reads FRAME_CYCLES-4.
  localparam logic [19:0]   WAIT_LAST  = 20'(FRAME_CYCLES - 4);
  localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO   = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      po_data_q, po_data_d;
  logic            po_flag_q, po_flag_d;
  logic [19:0]     wait_cnt_q, wait_cnt_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push;
  logic            pop;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign in_ready = (cnt_q != CNT_FULL);

  // A push coinciding with clr is discarded.
  assign push = in_valid && in_ready && !clr;
  // The cnt check is belt-and-braces; IDLE only advances to LOAD when non-empty.
  assign pop  = (state_q == ST_LOAD) && (cnt_q != CNT_ZERO);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage is not reset; contents are only read behind a valid count.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pacing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    po_data_d  = po_data_q;
    po_flag_d  = 1'b0;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // Do not start a frame on a byte that is being flushed this cycle.
        if ((cnt_q != CNT_ZERO) && !clr) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        po_data_d = mem_q[rd_ptr_q];
        po_flag_d = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 20'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      po_data_q  <= 8'h00;
      po_flag_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      po_data_q  <= po_data_d;
      po_flag_q  <= po_flag_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign po_data  = po_data_q;
  assign po_flag  = po_flag_q;
  assign busy     = (state_q != ST_IDLE);
  assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int FRAME = 550;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       in_valid  = 1'b0;
  logic       clr       = 1'b0;
  logic       in_ready;
  logic [7:0] po_data;
  logic       po_flag;
  logic       busy;
  logic [4:0] fifo_cnt;

  uart_tx_feeder #(
    .UART_BPS  (1_000_000),
    .CLK_FREQ  (50_000_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clr      (clr),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Record every cycle in which po_flag is high, with the byte on po_data.
  int         pulse_cyc[$];
  logic [7:0] pulse_dat[$];
  int         acc_cyc[$];

  always @(negedge sys_clk) begin
    if (po_flag === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(po_data);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    pulse_cyc.delete();
    pulse_dat.delete();
    acc_cyc.delete();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  // Push n consecutive byte values starting at first, valid held back-to-back.
  task automatic push_list(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      int budget;
      @(negedge sys_clk);
      in_data  = first + 8'(i);
      in_valid = 1'b1;
      budget   = 0;
      while (!in_ready && budget < 2000) begin
        @(negedge sys_clk);
        budget++;
      end
      if (!in_ready) begin
        chk("push_timeout", 32'(in_ready), 32'd1);
        break;
      end
      @(posedge sys_clk);
      #1;
      acc_cyc.push_back(cyc);
    end
    @(negedge sys_clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int k = 0;
    while (pulse_cyc.size() < n && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    chk(tag, 32'(pulse_cyc.size()), 32'(n));
  endtask

  // Check data order and exact FRAME spacing of the first n recorded pulses.
  task automatic check_train(input string tag, input int n, input logic [7:0] first);
    for (int i = 0; i < n && i < pulse_cyc.size(); i++) begin
      chk({tag, "_data"}, 32'(pulse_dat[i]), 32'(first + 8'(i)));
      if (i > 0) chk({tag, "_gap"}, 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(FRAME));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_fifo_cnt"}, 32'(fifo_cnt), 32'd0);
    chk({tag, "_po_flag"},  32'(po_flag),  32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_po_data"},  32'(po_data),  32'h00);
  endtask

  initial begin
    int p;

    // 1: reset and idle
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("t1_rst");
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("t1_no_pulse", 32'(pulse_cyc.size()), 32'd0);
    chk("t1_idle_ready", 32'(in_ready), 32'd1);

    // 2: single byte, latency 2 cycles after accept
    clear_logs();
    push_list(1, 8'hA5);
    wait_pulses(1, 50, "t2_pulse");
    if (pulse_cyc.size() >= 1 && acc_cyc.size() >= 1) begin
      p = pulse_cyc[0];
      chk("t2_latency", 32'(p - acc_cyc[0]), 32'd2);
      chk("t2_data", 32'(pulse_dat[0]), 32'hA5);
      wait_until(p + 300);
      chk("t2_busy_mid", 32'(busy), 32'd1);
      chk("t2_hold", 32'(po_data), 32'hA5);
      wait_until(p + 560);
      chk("t2_busy_end", 32'(busy), 32'd0);
      chk("t2_one_pulse", 32'(pulse_cyc.size()), 32'd1);
    end

    // 3: three bytes back-to-back, exact spacing
    clear_logs();
    push_list(3, 8'h01);
    if (acc_cyc.size() >= 1) begin
      p = acc_cyc[0] + 2;
      wait_until(p + 300);
      chk("t3_busy_f0", 32'(busy), 32'd1);
      wait_until(p + FRAME + 300);
      chk("t3_busy_f1", 32'(busy), 32'd1);
    end
    wait_pulses(3, 3 * FRAME + 100, "t3_pulses");
    check_train("t3", 3, 8'h01);
    if (pulse_cyc.size() >= 3) begin
      chk("t3_latency", 32'(pulse_cyc[0] - acc_cyc[0]), 32'd2);
      wait_until(pulse_cyc[2] + 560);
      chk("t3_busy_end", 32'(busy), 32'd0);
      chk("t3_cnt_end", 32'(fifo_cnt), 32'd0);
    end

    // 4: fill to full, then one more byte that must stall until space frees
    clear_logs();
    push_list(17, 8'h10);
    chk("t4_full_cnt", 32'(fifo_cnt), 32'(DEPTH));
    chk("t4_full_ready", 32'(in_ready), 32'd0);
    push_list(1, 8'h21);
    chk("t4_accepts", 32'(acc_cyc.size()), 32'd18);
    wait_pulses(18, 18 * FRAME + 200, "t4_pulses");
    check_train("t4", 18, 8'h10);
    wait_until(cyc + 600);
    chk("t4_no_extra", 32'(pulse_cyc.size()), 32'd18);
    chk("t4_cnt_end", 32'(fifo_cnt), 32'd0);

    // 5: clr during the first frame drops the remaining bytes
    clear_logs();
    push_list(4, 8'h41);
    wait_pulses(1, 50, "t5_first");
    if (pulse_cyc.size() >= 1) begin
      p = pulse_cyc[0];
      wait_until(p + 100);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(negedge sys_clk);
      clr      = 1'b0;
      in_valid = 1'b0;
      chk("t5_cnt_clr", 32'(fifo_cnt), 32'd0);
      chk("t5_ready_clr", 32'(in_ready), 32'd1);
      chk("t5_busy_clr", 32'(busy), 32'd1);
      chk("t5_hold", 32'(po_data), 32'h41);
      wait_until(p + 2 * FRAME + 100);
      chk("t5_one_pulse", 32'(pulse_cyc.size()), 32'd1);
      chk("t5_data", 32'(pulse_dat[0]), 32'h41);
      chk("t5_busy_end", 32'(busy), 32'd0);
      chk("t5_cnt_end", 32'(fifo_cnt), 32'd0);
    end

    // 6: reset mid-WAIT, then normal operation
    clear_logs();
    push_list(1, 8'h77);
    wait_pulses(1, 50, "t6_first");
    if (pulse_cyc.size() >= 1) wait_until(pulse_cyc[0] + 200);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_reset_outputs("t6_rst");
    sys_rst_n = 1'b1;
    clear_logs();
    push_list(1, 8'h3C);
    wait_pulses(1, 50, "t6_pulse");
    if (pulse_cyc.size() >= 1 && acc_cyc.size() >= 1) begin
      p = pulse_cyc[0];
      chk("t6_latency", 32'(p - acc_cyc[0]), 32'd2);
      chk("t6_data", 32'(pulse_dat[0]), 32'h3C);
      wait_until(p + 600);
      chk("t6_one_pulse", 32'(pulse_cyc.size()), 32'd1);
      chk("t6_busy_end", 32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
